// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding select
// encodings, the mult/div tracker state type and the default register address width.
package mips_pkg;

    localparam int DEF_REG_AW = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_ME = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/dff.sv
// Generic W-bit register with synchronous active-high reset to zero.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/sat_counter.sv
// Event counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard unit: EX forwarding selects, load-use and mult/div stalls,
// branch/jump flushes and saturating stall/flush event counters.
module hazard_ctl
    import mips_pkg::*;
#(
    parameter int REG_AW     = DEF_REG_AW,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs_ID,
    input  logic [REG_AW-1:0] Rt_ID,
    input  logic              UsesRs_ID,
    input  logic              UsesRt_ID,
    input  logic              MdStart_ID,
    input  logic              MdUse_ID,
    input  logic              Jump_ID,
    input  logic [REG_AW-1:0] Rs_EX,
    input  logic [REG_AW-1:0] Rt_EX,
    input  logic [REG_AW-1:0] WriteReg_EX,
    input  logic [REG_AW-1:0] WriteReg_ME,
    input  logic [REG_AW-1:0] WriteReg_WB,
    input  logic              RegWrite_EX,
    input  logic              RegWrite_ME,
    input  logic              RegWrite_WB,
    input  logic              MemToReg_EX,
    input  logic              BranchTaken_EX,
    output logic [1:0]        FwdA_EX,
    output logic [1:0]        FwdB_EX,
    output logic              Stall_IF,
    output logic              Stall_ID,
    output logic              Flush_ID,
    output logic              Flush_EX,
    output logic              AnyStall,
    output logic              MdBusy,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam int MD_CW = $clog2(MD_LATENCY + 1);

    md_state_t        state_q, state_d;
    logic [0:0]       state_raw_q;
    logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
    logic             load_use, md_stall, redirect, stall, md_accept;

    // Register 0 is hardwired to zero, so a write to it never produces a hazard.
    function automatic logic writes_reg(input logic we,
                                        input logic [REG_AW-1:0] dst,
                                        input logic [REG_AW-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

    always_comb begin
        FwdA_EX = FWD_RF;
        FwdB_EX = FWD_RF;
        if (writes_reg(RegWrite_ME, WriteReg_ME, Rs_EX))      FwdA_EX = FWD_ME;
        else if (writes_reg(RegWrite_WB, WriteReg_WB, Rs_EX)) FwdA_EX = FWD_WB;
        if (writes_reg(RegWrite_ME, WriteReg_ME, Rt_EX))      FwdB_EX = FWD_ME;
        else if (writes_reg(RegWrite_WB, WriteReg_WB, Rt_EX)) FwdB_EX = FWD_WB;
    end

    always_comb begin
        load_use = MemToReg_EX &&
                   ((UsesRs_ID && writes_reg(RegWrite_EX, WriteReg_EX, Rs_ID)) ||
                    (UsesRt_ID && writes_reg(RegWrite_EX, WriteReg_EX, Rt_ID)));
        md_stall  = MdUse_ID && MdBusy;
        redirect  = BranchTaken_EX;
        // A taken branch squashes whatever would have stalled, so it wins.
        stall     = (load_use || md_stall) && !redirect;
        md_accept = MdStart_ID && !stall && !redirect;
    end

    assign Stall_IF = stall;
    assign Stall_ID = stall;
    assign AnyStall = stall;
    assign Flush_EX = redirect || load_use || md_stall;
    assign Flush_ID = redirect || (Jump_ID && !stall);

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_accept) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_CW'(MD_LATENCY);
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - MD_CW'(1);
                if (md_cnt_q == MD_CW'(1)) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    dff #(.W(1)) u_state_dff (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (state_raw_q)
    );
    assign state_q = md_state_t'(state_raw_q);

    always_ff @(posedge clk) begin
        if (reset) md_cnt_q <= '0;
        else       md_cnt_q <= md_cnt_d;
    end

    assign MdBusy = (state_q == MD_BUSY);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (Flush_ID || Flush_EX),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl with MD_LATENCY=4 and 3-bit counters so
// saturation is reachable in a handful of cycles.
module tb_hazard_ctl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] rs_id, rt_id, rs_ex, rt_ex, wr_ex, wr_me, wr_wb;
    logic              uses_rs_id, uses_rt_id, md_start_id, md_use_id, jump_id;
    logic              rw_ex, rw_me, rw_wb, mem_to_reg_ex, branch_taken_ex;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall_if, stall_id, flush_id, flush_ex, any_stall, md_busy;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    hazard_ctl #(.REG_AW(REG_AW), .MD_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .Rs_ID          (rs_id),
        .Rt_ID          (rt_id),
        .UsesRs_ID      (uses_rs_id),
        .UsesRt_ID      (uses_rt_id),
        .MdStart_ID     (md_start_id),
        .MdUse_ID       (md_use_id),
        .Jump_ID        (jump_id),
        .Rs_EX          (rs_ex),
        .Rt_EX          (rt_ex),
        .WriteReg_EX    (wr_ex),
        .WriteReg_ME    (wr_me),
        .WriteReg_WB    (wr_wb),
        .RegWrite_EX    (rw_ex),
        .RegWrite_ME    (rw_me),
        .RegWrite_WB    (rw_wb),
        .MemToReg_EX    (mem_to_reg_ex),
        .BranchTaken_EX (branch_taken_ex),
        .FwdA_EX        (fwd_a),
        .FwdB_EX        (fwd_b),
        .Stall_IF       (stall_if),
        .Stall_ID       (stall_id),
        .Flush_ID       (flush_id),
        .Flush_EX       (flush_ex),
        .AnyStall       (any_stall),
        .MdBusy         (md_busy),
        .StallCnt       (stall_cnt),
        .FlushCnt       (flush_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Returns every decode/execute input to a quiet, hazard-free value.
    task automatic applyStimulus();
        rs_id = '0; rt_id = '0; rs_ex = '0; rt_ex = '0;
        wr_ex = '0; wr_me = '0; wr_wb = '0;
        uses_rs_id = 1'b0; uses_rt_id = 1'b0;
        md_start_id = 1'b0; md_use_id = 1'b0; jump_id = 1'b0;
        rw_ex = 1'b0; rw_me = 1'b0; rw_wb = 1'b0;
        mem_to_reg_ex = 1'b0; branch_taken_ex = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use_hit();
        mem_to_reg_ex = 1'b1; rw_ex = 1'b1; wr_ex = 5'd9;
        rt_id = 5'd9; uses_rt_id = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus();
        tick();
        tick();
        checkOutput("reset_mdbusy", 32'(md_busy), 0);
        checkOutput("reset_stallcnt", 32'(stall_cnt), 0);
        checkOutput("reset_flushcnt", 32'(flush_cnt), 0);
        reset = 1'b0;

        // Forwarding priority and register-0 exclusion
        rw_me = 1'b1; wr_me = 5'd8; rw_wb = 1'b1; wr_wb = 5'd8; rs_ex = 5'd8; rt_ex = 5'd8;
        #1;
        checkOutput("fwdA_me_prio", 32'(fwd_a), 1);
        checkOutput("fwdB_me_prio", 32'(fwd_b), 1);
        rw_me = 1'b0;
        #1;
        checkOutput("fwdA_wb", 32'(fwd_a), 2);
        rw_me = 1'b1; wr_me = 5'd0; wr_wb = 5'd0; rs_ex = 5'd0; rt_ex = 5'd0;
        #1;
        checkOutput("fwdA_r0", 32'(fwd_a), 0);
        checkOutput("fwdB_r0", 32'(fwd_b), 0);
        wr_me = 5'd3; wr_wb = 5'd4; rs_ex = 5'd3; rt_ex = 5'd4;
        #1;
        checkOutput("fwdA_split_me", 32'(fwd_a), 1);
        checkOutput("fwdB_split_wb", 32'(fwd_b), 2);
        applyStimulus();
        #1;

        // Load-use: one stall cycle, then cleared
        set_load_use_hit();
        #1;
        checkOutput("lu_stall_if", 32'(stall_if), 1);
        checkOutput("lu_stall_id", 32'(stall_id), 1);
        checkOutput("lu_anystall", 32'(any_stall), 1);
        checkOutput("lu_flush_ex", 32'(flush_ex), 1);
        checkOutput("lu_flush_id", 32'(flush_id), 0);
        tick();
        applyStimulus();
        #1;
        checkOutput("lu_released", 32'(stall_id), 0);
        checkOutput("lu_stallcnt", 32'(stall_cnt), 1);
        checkOutput("lu_flushcnt", 32'(flush_cnt), 1);
        set_load_use_hit();
        uses_rt_id = 1'b0;
        #1;
        checkOutput("lu_unused_rt", 32'(stall_id), 0);
        uses_rt_id = 1'b1; wr_ex = 5'd0; rt_id = 5'd0;
        #1;
        checkOutput("lu_r0", 32'(stall_id), 0);
        applyStimulus();
        tick();
        checkOutput("lu_cnt_hold", 32'(stall_cnt), 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Mult/div occupancy with a dependent mfhi held in decode
        md_start_id = 1'b1; md_use_id = 1'b1;
        #1;
        checkOutput("md_issue_nostall", 32'(stall_id), 0);
        tick();
        md_start_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("md_busy_c%0d", i + 1), 32'(md_busy), 1);
            checkOutput($sformatf("md_stall_c%0d", i + 1), 32'(stall_id), 1);
            tick();
        end
        checkOutput("md_idle_after", 32'(md_busy), 0);
        checkOutput("md_released", 32'(stall_id), 0);
        checkOutput("md_stallcnt", 32'(stall_cnt), 4);
        checkOutput("md_flushcnt", 32'(flush_cnt), 4);
        applyStimulus();

        // Redirect overrides load-use stall and a same-cycle mult/div start
        set_load_use_hit();
        md_start_id = 1'b1; md_use_id = 1'b1; branch_taken_ex = 1'b1;
        #1;
        checkOutput("br_no_stall", 32'(stall_id), 0);
        checkOutput("br_flush_id", 32'(flush_id), 1);
        checkOutput("br_flush_ex", 32'(flush_ex), 1);
        tick();
        applyStimulus();
        #1;
        checkOutput("br_md_stays_idle", 32'(md_busy), 0);
        checkOutput("br_flushcnt", 32'(flush_cnt), 5);
        checkOutput("br_stallcnt", 32'(stall_cnt), 4);
        jump_id = 1'b1;
        #1;
        checkOutput("jmp_flush_id", 32'(flush_id), 1);
        checkOutput("jmp_flush_ex", 32'(flush_ex), 0);
        set_load_use_hit();
        #1;
        checkOutput("jmp_stalled_no_flush_id", 32'(flush_id), 0);
        applyStimulus();

        // Reset in the second BUSY cycle drops tracking; next start works normally
        md_start_id = 1'b1; md_use_id = 1'b1;
        tick();
        applyStimulus();
        tick();
        checkOutput("rst_pre_busy", 32'(md_busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_mdbusy", 32'(md_busy), 0);
        checkOutput("rst_stallcnt", 32'(stall_cnt), 0);
        checkOutput("rst_flushcnt", 32'(flush_cnt), 0);
        md_start_id = 1'b1; md_use_id = 1'b1;
        tick();
        applyStimulus();
        checkOutput("rst_restart_busy", 32'(md_busy), 1);
        tick(); tick(); tick();
        checkOutput("rst_restart_last", 32'(md_busy), 1);
        tick();
        checkOutput("rst_restart_done", 32'(md_busy), 0);

        // Saturation of 3-bit counters under ten stall cycles
        set_load_use_hit();
        for (int i = 1; i <= 10; i++) begin
            tick();
            checkOutput($sformatf("sat_stall_%0d", i), 32'(stall_cnt), (i > 7) ? 7 : i);
        end
        checkOutput("sat_flushcnt", 32'(flush_cnt), 7);
        applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
